// File: rtl/case_4_sdiv_9s_2s_9_seq.sv
// case_4_sdiv_9s_2s_9_seq: sequential signed restoring divider with C truncating semantics and valid/ready handshake
module case_4_sdiv_9s_2s_9_seq #(
  parameter int DIVIDEND_WIDTH = 9,
  parameter int DIVISOR_WIDTH  = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_zero,
  output logic                      overflow
);
  localparam int N  = DIVIDEND_WIDTH;
  localparam int M  = DIVISOR_WIDTH;
  localparam int R  = M + 1;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic sa, sb, dz, ovf;
  logic [N-1:0] a_mag;
  logic [M-1:0] b_mag;
  logic [R-1:0] rem;
  logic [CW-1:0] cnt;
  logic [R:0] shifted, diff;
  logic ge;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign shifted   = {rem, a_mag[N-1]};
  assign diff      = shifted - {2'b00, b_mag};
  assign ge        = shifted >= {2'b00, b_mag};
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      a_mag     <= '0;
      b_mag     <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa    <= dividend[N-1];
          sb    <= divisor[M-1];
          a_mag <= dividend[N-1] ? -dividend : dividend;
          b_mag <= divisor[M-1] ? -divisor : divisor;
          dz    <= divisor == '0;
          ovf   <= dividend == {1'b1, {(N-1){1'b0}}} && divisor == '1;
          rem   <= '0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: if (dz || cnt == CW'(N)) begin
          // a_mag now holds the unsigned quotient; the N-bit negate gives the two's-complement wrap
          quotient  <= dz ? '1 : (sa ^ sb) ? -a_mag : a_mag;
          remainder <= dz ? '0 : sa ? -M'(rem) : M'(rem);
          div_zero  <= dz;
          overflow  <= ovf && !dz;
          state     <= DONE;
        end else begin
          rem   <= R'(ge ? diff : shifted);
          a_mag <= {a_mag[N-2:0], ge};
          cnt   <= cnt + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
